// File: rtl/idct8_mul_sched.sv
// idct8_mul_sched: runs an 8-point IDCT8 through one shared pipelined multiplier, with rounding, shift and clip.
// Optional build macro IDCT8_MUL_SCHED_SAT_EN makes the accumulator saturate instead of wrapping.
module idct8_mul_sched #(
  parameter int SHIFT = 7,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic [5:0]       coef_addr,
  input  logic [7:0]       coef_q,
  output logic [7:0]       mul_din0,
  output logic [31:0]      mul_din1,
  output logic             mul_ce,
  input  logic [31:0]      mul_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last
);

  typedef enum logic [1:0] {LOAD, ISSUE, DRAIN, OUT} state_t;

  localparam logic signed [32:0] ROUND =
    (SHIFT > 0) ? (33'sd1 <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : 33'sd0;
  localparam logic signed [32:0] OMAX = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
  localparam logic signed [32:0] OMIN = -(33'sd1 <<< (OUT_W - 1));

  state_t                   state;
  state_t                   state_nxt;
  logic [2:0]               n;
  logic [2:0]               k;
  logic [1:0]               drain_cnt;
  logic                     v1;
  logic                     v2;
  logic [2:0]               n_d1;
  logic signed [31:0]       x [8];
  logic signed [31:0]       acc;
  logic [7:0]               din0_q;
  logic [31:0]              din1_q;
  logic signed [32:0]       rnd_sum;
  logic signed [32:0]       shifted;
  logic [OUT_W-1:0]         clip_val;

  // Accumulator add; the 33-bit sum exposes signed overflow for the saturating build.
  function automatic logic signed [31:0] acc_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
    logic signed [32:0] s;
    s = {a[31], a} + {b[31], b};
`ifdef IDCT8_MUL_SCHED_SAT_EN
    if (s[32] != s[31]) begin
      return s[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    end else begin
      return s[31:0];
    end
`else
    return s[31:0];
`endif
  endfunction

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    state_nxt = (in_valid && n == 3'd7) ? ISSUE : LOAD;
      ISSUE:   state_nxt = (n == 3'd7) ? DRAIN : ISSUE;
      DRAIN:   state_nxt = (drain_cnt == 2'd2) ? OUT : DRAIN;
      OUT:     state_nxt = out_ready ? ((k == 3'd7) ? LOAD : ISSUE) : OUT;
      default: state_nxt = LOAD;
    endcase
  end

  // Round, arithmetic shift and saturate the finished row sum.
  always_comb begin
    rnd_sum = $signed({acc[31], acc}) + ROUND;
    shifted = rnd_sum >>> SHIFT;
    if (shifted > OMAX) begin
      clip_val = OMAX[OUT_W-1:0];
    end else if (shifted < OMIN) begin
      clip_val = OMIN[OUT_W-1:0];
    end else begin
      clip_val = shifted[OUT_W-1:0];
    end
  end

  // State, sample/row counters, drain timer and the registered result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= LOAD;
      n         <= 3'd0;
      k         <= 3'd0;
      drain_cnt <= 2'd0;
      out_data  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        LOAD: begin
          if (in_valid) n <= n + 3'd1;
        end
        ISSUE: begin
          n         <= n + 3'd1;
          drain_cnt <= 2'd0;
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 2'd1;
          if (drain_cnt == 2'd2) out_data <= clip_val;
        end
        OUT: begin
          if (out_ready) begin
            k <= (k == 3'd7) ? 3'd0 : k + 3'd1;
            n <= 3'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // Sample buffer, written only while loading.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) x[i] <= 32'sd0;
    end else if (state == LOAD && in_valid) begin
      x[n] <= in_data;
    end
  end

  // Multiplier pipeline tracking and operand hold registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      n_d1   <= 3'd0;
      din0_q <= 8'd0;
      din1_q <= 32'd0;
    end else begin
      v1   <= (state == ISSUE);
      v2   <= v1;
      n_d1 <= n;
      if (v1) begin
        din0_q <= coef_q;
        din1_q <= x[n_d1];
      end
    end
  end

  // Row accumulator: cleared at the start of every row, fed one product per valid stage-2 cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= 32'sd0;
    end else if ((state == LOAD && in_valid && n == 3'd7) || (state == OUT && out_ready)) begin
      acc <= 32'sd0;
    end else if (v2) begin
      acc <= acc_add(acc, $signed(mul_dout));
    end
  end

  // The ROM answers one cycle after coef_addr, so stage 1 forwards coef_q straight to the multiplier.
  assign in_ready  = (state == LOAD);
  assign out_valid = (state == OUT);
  assign out_last  = (state == OUT) && (k == 3'd7);
  assign coef_addr = {k, n};
  assign mul_ce    = v1;
  assign mul_din0  = v1 ? coef_q : din0_q;
  assign mul_din1  = v1 ? x[n_d1] : din1_q;

endmodule

// File: tb/tb_idct8_mul_sched.sv
// Randomised self-checking bench for idct8_mul_sched with ROM and multiplier models and a
// plain-arithmetic reference of the row transform.
module tb_idct8_mul_sched;
  localparam int SHIFT = 7;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_data;
  logic [5:0]         coef_addr;
  logic [7:0]         coef_q = 8'd0;
  logic [7:0]         mul_din0;
  logic [31:0]        mul_din1;
  logic               mul_ce;
  logic [31:0]        mul_dout = 32'd0;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic               out_last;

  logic signed [7:0]  rom [64];
  int                 xs [8];
  int                 n_tests = 0;
  int                 n_fail = 0;

  idct8_mul_sched #(.SHIFT(SHIFT), .OUT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_addr(coef_addr), .coef_q(coef_q), .mul_din0(mul_din0), .mul_din1(mul_din1),
    .mul_ce(mul_ce), .mul_dout(mul_dout), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Synchronous coefficient ROM and the shared 1-cycle multiplier.
  always @(posedge clk) coef_q <= rom[coef_addr];
  always @(posedge clk) if (mul_ce) mul_dout <= $signed(mul_din0) * $signed(mul_din1);

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // y[k] = clip((sum_n c[k][n]*x[n] + round) >>> SHIFT), products truncated to 32 bits.
  function automatic logic signed [63:0] ref_y(input int k);
    longint acc = 0;
    longint s;
    int p32;
    for (int n = 0; n < 8; n++) begin
      p32 = int'(longint'(rom[k*8+n]) * longint'(xs[n]));
`ifdef IDCT8_MUL_SCHED_SAT_EN
      acc = acc + longint'(p32);
      if (acc > 64'sd2147483647) acc = 64'sd2147483647;
      else if (acc < -64'sd2147483648) acc = -64'sd2147483648;
`else
      acc = longint'(int'(acc + longint'(p32)));
`endif
    end
    s = (acc + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
    if (s > 64'sd32767) s = 64'sd32767;
    else if (s < -64'sd32768) s = -64'sd32768;
    return s;
  endfunction

  task automatic fill_rom(input int mode, input int val);
    for (int i = 0; i < 64; i++) rom[i] = (mode == 0) ? 8'(val) : 8'($urandom);
  endtask

  task automatic do_load();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = xs[i];
      check("load_in_ready", 64'(in_ready), 64'sd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  // Runs the 8 rows; optionally stalls row hold_k or resets 4 cycles into row rst_k.
  task automatic run_rows(input int hold_k, input int rst_k);
    int cnt;
    int ce;
    logic [5:0] addr;
    for (int k = 0; k < 8; k++) begin
      check("busy_in_ready", 64'(in_ready), 64'sd0);
      if (k == rst_k) begin
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'sd0);
        check("rst_mul_ce", 64'(mul_ce), 64'sd0);
        check("rst_in_ready", 64'(in_ready), 64'sd1);
        @(posedge clk); #1;
        reset = 1'b1;
        return;
      end
      cnt = 0;
      ce  = 0;
      while (!out_valid && cnt < 40) begin
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        cnt++;
        if (mul_ce) ce++;
      end
      check("row_latency", 64'(cnt), 64'sd11);
      check("row_mul_ce_count", 64'(ce), 64'sd8);
      check("y", 64'(out_data), ref_y(k));
      check("out_last", 64'(out_last), (k == 7) ? 64'sd1 : 64'sd0);
      if (k == hold_k) begin
        out_ready = 1'b0;
        addr = coef_addr;
        repeat (5) begin
          @(posedge clk); #1;
          check("hold_valid", 64'(out_valid), 64'sd1);
          check("hold_y", 64'(out_data), ref_y(k));
          check("hold_mul_ce", 64'(mul_ce), 64'sd0);
          check("hold_addr", 64'(coef_addr), 64'(addr));
        end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      if (k == 7) begin
        check("end_out_valid", 64'(out_valid), 64'sd0);
        check("end_in_ready", 64'(in_ready), 64'sd1);
      end
    end
  endtask

  task automatic set_x(input int x0, input int rest);
    xs[0] = x0;
    for (int i = 1; i < 8; i++) xs[i] = rest;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 32'd0;
    fill_rom(0, 1);
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 64'(in_ready), 64'sd1);
    check("reset_mul_ce", 64'(mul_ce), 64'sd0);
    check("reset_out_valid", 64'(out_valid), 64'sd0);
    check("reset_out_last", 64'(out_last), 64'sd0);
    check("reset_out_data", 64'(out_data), 64'sd0);
    check("reset_coef_addr", 64'(coef_addr), 64'sd0);
    check("reset_din0", 64'(mul_din0), 64'sd0);
    check("reset_din1", 64'(mul_din1), 64'sd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Unit coefficients: flat input, then the rounding corner cases.
    for (int i = 0; i < 8; i++) xs[i] = 128;
    do_load(); run_rows(-1, -1);
    set_x(64, 0);  do_load(); run_rows(-1, -1);
    set_x(-64, 0); do_load(); run_rows(-1, -1);
    set_x(-65, 0); do_load(); run_rows(-1, -1);

    // Large coefficients: output clip, then accumulator overflow.
    fill_rom(0, 127);
    set_x(1 << 20, 1 << 20); do_load(); run_rows(-1, -1);
    set_x(1 << 22, 1 << 22); do_load(); run_rows(-1, -1);

    // Random transform with a 5-cycle stall on row 3.
    fill_rom(1, 0);
    for (int i = 0; i < 8; i++) xs[i] = int'($urandom) >>> $urandom_range(8, 24);
    do_load(); run_rows(3, -1);

    // Reset in the middle of row 2, then a fresh transform must be clean.
    fill_rom(1, 0);
    for (int i = 0; i < 8; i++) xs[i] = int'($urandom) >>> $urandom_range(8, 24);
    do_load(); run_rows(-1, 2);
    for (int i = 0; i < 8; i++) xs[i] = int'($urandom) >>> $urandom_range(8, 24);
    do_load(); run_rows(-1, -1);

    // Random transforms over a wide range of magnitudes, including wrap-prone ones.
    for (int t = 0; t < 6; t++) begin
      fill_rom(1, 0);
      for (int i = 0; i < 8; i++) xs[i] = int'($urandom) >>> $urandom_range(0, 24);
      do_load(); run_rows(-1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
